// File: rtl/mem_lsu_ctrl_pkg.sv
// Shared types and constants for the MEM-stage load/store unit.
package mem_lsu_ctrl_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int WAIT_W = 4;

    typedef enum logic [1:0] {
        LSU_ST_IDLE,
        LSU_ST_REQ,
        LSU_ST_RESP,
        LSU_ST_DONE
    } lsu_state_e;

endpackage

// File: rtl/mem_lsu_ctrl_if.sv
// Data-memory port: req/gnt request phase, rvalid/rdata response phase.
interface mem_lsu_ctrl_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  req;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [3:0]            be;
    logic [31:0]           wdata;
    logic                  gnt;
    logic                  rvalid;
    logic [31:0]           rdata;

    modport master (
        output req, we, addr, be, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, be, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/mem_lsu_ctrl_align.sv
// Store lane formatting, load extraction/extension, misalign and
// illegal-size detection. Purely combinational.
module mem_lsu_ctrl_align
    import mem_lsu_ctrl_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  off_i,
    input  logic        we_i,
    input  logic [31:0] wdata_i,
    input  logic [2:0]  ld_funct3_i,
    input  logic [1:0]  ld_off_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic        bad_o,
    output logic [31:0] ldata_o
);
    logic [31:0] sh;

    always_comb begin
        be_o    = 4'b0000;
        wdata_o = 32'h0;
        // Unsigned variants exist only for sub-word loads.
        bad_o   = funct3_i[2] & (we_i | funct3_i[1]);
        unique case (funct3_i[1:0])
            2'b00: begin
                be_o    = 4'b0001 << off_i;
                wdata_o = {4{wdata_i[7:0]}};
            end
            2'b01: begin
                be_o    = 4'b0011 << off_i;
                wdata_o = {2{wdata_i[15:0]}};
                bad_o   = bad_o | off_i[0];
            end
            2'b10: begin
                be_o    = 4'b1111;
                wdata_o = wdata_i;
                bad_o   = bad_o | (off_i != 2'b00);
            end
            default: bad_o = 1'b1;
        endcase
    end

    always_comb begin
        sh = rdata_i >> {ld_off_i, 3'b000};
        unique case (ld_funct3_i)
            F3_B:    ldata_o = {{24{sh[7]}}, sh[7:0]};
            F3_H:    ldata_o = {{16{sh[15]}}, sh[15:0]};
            F3_BU:   ldata_o = {24'h0, sh[7:0]};
            F3_HU:   ldata_o = {16'h0, sh[15:0]};
            default: ldata_o = sh;
        endcase
    end
endmodule

// File: rtl/mem_lsu_ctrl.sv
// MEM-stage load/store unit: drives the data-memory port and holds the
// pipeline with stall_o until each access completes.
module mem_lsu_ctrl
    import mem_lsu_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int MAX_WAIT   = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mem_read_i,
    input  logic                  mem_write_i,
    input  logic [2:0]            funct3_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [31:0]           wdata_i,
    input  logic                  flush_i,
    mem_lsu_ctrl_if.master        dmem,
    output logic                  stall_o,
    output logic [31:0]           load_data_o,
    output logic                  load_valid_o,
    output logic                  misalign_o,
    output logic                  timeout_o
);
    lsu_state_e            state_q;
    logic                  req_q, we_q, discard_q;
    logic                  ldv_q, mis_q, tmo_q;
    logic [2:0]            f3_q;
    logic [1:0]            off_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [3:0]            be_q;
    logic [31:0]           wd_q, ld_q;
    logic [WAIT_W-1:0]     wait_q;

    logic        access, bad, accept, busy, mem_op, wait_end;
    logic [3:0]  be_d;
    logic [31:0] wd_d, ld_d;

    mem_lsu_ctrl_align u_align (
        .funct3_i    (funct3_i),
        .off_i       (addr_i[1:0]),
        .we_i        (mem_write_i),
        .wdata_i     (wdata_i),
        .ld_funct3_i (f3_q),
        .ld_off_i    (off_q),
        .rdata_i     (dmem.rdata),
        .be_o        (be_d),
        .wdata_o     (wd_d),
        .bad_o       (bad),
        .ldata_o     (ld_d)
    );

    assign mem_op   = mem_read_i | mem_write_i;
    assign access   = (state_q == LSU_ST_IDLE) & mem_op & ~flush_i;
    assign accept   = access & ~bad;
    assign busy     = (state_q == LSU_ST_REQ) | (state_q == LSU_ST_RESP);
    assign wait_end = (wait_q == WAIT_W'(MAX_WAIT - 1));

    // A discarded read still owes an rvalid; hold any new access until it drains.
    assign stall_o = (busy & ~discard_q & ~flush_i) | accept
                   | (discard_q & mem_op);

    assign dmem.req     = req_q;
    assign dmem.we      = we_q;
    assign dmem.addr    = addr_q;
    assign dmem.be      = be_q;
    assign dmem.wdata   = wd_q;
    assign load_data_o  = ld_q;
    assign load_valid_o = ldv_q;
    assign misalign_o   = mis_q;
    assign timeout_o    = tmo_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= LSU_ST_IDLE;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            discard_q <= 1'b0;
            ldv_q     <= 1'b0;
            mis_q     <= 1'b0;
            tmo_q     <= 1'b0;
            f3_q      <= 3'b000;
            off_q     <= 2'b00;
            addr_q    <= '0;
            be_q      <= 4'b0000;
            wd_q      <= 32'h0;
            ld_q      <= 32'h0;
            wait_q    <= '0;
        end else begin
            ldv_q <= 1'b0;
            mis_q <= 1'b0;
            tmo_q <= 1'b0;
            unique case (state_q)
                LSU_ST_IDLE: begin
                    if (access && bad) begin
                        mis_q <= 1'b1;
                    end else if (access) begin
                        state_q   <= LSU_ST_REQ;
                        req_q     <= 1'b1;
                        we_q      <= mem_write_i;
                        f3_q      <= funct3_i;
                        off_q     <= addr_i[1:0];
                        addr_q    <= {addr_i[ADDR_WIDTH-1:2], 2'b00};
                        be_q      <= be_d;
                        wd_q      <= wd_d;
                        wait_q    <= '0;
                        discard_q <= 1'b0;
                    end
                end
                LSU_ST_REQ: begin
                    if (dmem.gnt) begin
                        req_q  <= 1'b0;
                        wait_q <= '0;
                        if (we_q) begin
                            state_q <= flush_i ? LSU_ST_IDLE : LSU_ST_DONE;
                        end else begin
                            state_q   <= LSU_ST_RESP;
                            discard_q <= flush_i;
                        end
                    end else if (flush_i) begin
                        req_q   <= 1'b0;
                        state_q <= LSU_ST_IDLE;
                    end else if (wait_end) begin
                        req_q   <= 1'b0;
                        tmo_q   <= 1'b1;
                        wait_q  <= '0;
                        state_q <= LSU_ST_DONE;
                    end else begin
                        wait_q <= wait_q + 1'b1;
                    end
                end
                LSU_ST_RESP: begin
                    if (dmem.rvalid) begin
                        wait_q    <= '0;
                        discard_q <= 1'b0;
                        if (discard_q || flush_i) begin
                            state_q <= LSU_ST_IDLE;
                        end else begin
                            ld_q    <= ld_d;
                            ldv_q   <= 1'b1;
                            state_q <= LSU_ST_DONE;
                        end
                    end else if (wait_end) begin
                        tmo_q     <= 1'b1;
                        wait_q    <= '0;
                        discard_q <= 1'b0;
                        state_q   <= LSU_ST_DONE;
                    end else begin
                        wait_q <= wait_q + 1'b1;
                        if (flush_i) discard_q <= 1'b1;
                    end
                end
                default: state_q <= LSU_ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_lsu_ctrl.sv
// Scoreboard bench for mem_lsu_ctrl: bus requests and load results are
// queued at drive time and popped when the DUT produces them.
module tb_mem_lsu_ctrl;
    import mem_lsu_ctrl_pkg::*;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
    } bus_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_read_i, mem_write_i, flush_i;
    logic [2:0]  funct3_i;
    logic [31:0] addr_i, wdata_i;
    logic        stall_o, load_valid_o, misalign_o, timeout_o;
    logic [31:0] load_data_o;

    int   checks = 0;
    int   errors = 0;
    bus_t exp_bus[$];
    logic [31:0] exp_ld[$];
    bus_t mon_e;

    always #5 clk = ~clk;

    mem_lsu_ctrl_if #(.ADDR_WIDTH(32)) dmem_if ();

    mem_lsu_ctrl #(.ADDR_WIDTH(32), .MAX_WAIT(15)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mem_read_i   (mem_read_i),
        .mem_write_i  (mem_write_i),
        .funct3_i     (funct3_i),
        .addr_i       (addr_i),
        .wdata_i      (wdata_i),
        .flush_i      (flush_i),
        .dmem         (dmem_if),
        .stall_o      (stall_o),
        .load_data_o  (load_data_o),
        .load_valid_o (load_valid_o),
        .misalign_o   (misalign_o),
        .timeout_o    (timeout_o)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] m_be(input logic [2:0] f3,
                                        input logic [1:0] off);
        case (f3[1:0])
            2'd0:    return 4'b0001 << off;
            2'd1:    return off[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] m_wd(input logic [2:0] f3,
                                         input logic [31:0] wd);
        case (f3[1:0])
            2'd0:    return {4{wd[7:0]}};
            2'd1:    return {2{wd[15:0]}};
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] m_ld(input logic [2:0] f3,
                                         input logic [1:0] off,
                                         input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = rd[7:0];
            2'd1:    b = rd[15:8];
            2'd2:    b = rd[23:16];
            default: b = rd[31:24];
        endcase
        h = off[1] ? rd[31:16] : rd[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b100:  return {24'h0, b};
            3'b101:  return {16'h0, h};
            default: return rd;
        endcase
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (dmem_if.req && dmem_if.gnt) begin
                if (exp_bus.size() == 0) begin
                    chk("bus_unexpected", 32'd1, 32'd0);
                end else begin
                    mon_e = exp_bus.pop_front();
                    chk("bus_we", {31'h0, dmem_if.we}, {31'h0, mon_e.we});
                    chk("bus_addr", dmem_if.addr, mon_e.addr);
                    if (mon_e.we) begin
                        chk("bus_be", {28'h0, dmem_if.be}, {28'h0, mon_e.be});
                        chk("bus_wdata", dmem_if.wdata, mon_e.wd);
                    end
                end
            end
            if (dmem_if.rvalid)
                chk("rvalid_in_req", {31'h0, dmem_if.req}, 32'd0);
            if (load_valid_o) begin
                if (exp_ld.size() == 0)
                    chk("load_unexpected", 32'd1, 32'd0);
                else
                    chk("load_data", load_data_o, exp_ld.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_acc(input string tag, input bit wr,
                           input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input logic [31:0] rd,
                           input int gd, input int rdly);
        int   nst = 0;
        int   gcnt = 0;
        int   rcnt = 0;
        int   exp_nst;
        bit   rpend = 0;
        bit   st = 1;
        bit   lv = 0;
        bit   done = 0;
        bus_t e;
        e.we   = wr;
        e.addr = {a[31:2], 2'b00};
        e.be   = m_be(f3, a[1:0]);
        e.wd   = m_wd(f3, wd);
        exp_bus.push_back(e);
        if (!wr) exp_ld.push_back(m_ld(f3, a[1:0], rd));
        exp_nst = 1 + gd + 1 + (wr ? 0 : rdly + 1);
        mem_read_i  = !wr;
        mem_write_i = wr;
        funct3_i    = f3;
        addr_i      = a;
        wdata_i     = wd;
        for (int i = 0; i < 60 && !done; i++) begin
            dmem_if.gnt    = dmem_if.req && (gcnt == gd);
            dmem_if.rvalid = rpend && (rcnt == rdly);
            dmem_if.rdata  = dmem_if.rvalid ? rd : ~rd;
            #4;
            st = stall_o;
            lv = load_valid_o;
            if (st) nst++;
            if (dmem_if.rvalid) rpend = 0;
            else if (rpend) rcnt++;
            if (dmem_if.gnt && !wr) rpend = 1;
            if (dmem_if.req && !dmem_if.gnt) gcnt++;
            step();
            if (!st) done = 1;
        end
        mem_read_i     = 1'b0;
        mem_write_i    = 1'b0;
        dmem_if.gnt    = 1'b0;
        dmem_if.rvalid = 1'b0;
        chk({tag, "_done"}, {31'h0, done}, 32'd1);
        chk({tag, "_stall_cycles"}, nst, exp_nst);
        chk({tag, "_valid_pulse"}, {31'h0, lv}, {31'h0, !wr});
    endtask

    task automatic run_mis(input string tag, input bit wr,
                           input logic [2:0] f3, input logic [31:0] a);
        mem_read_i  = !wr;
        mem_write_i = wr;
        funct3_i    = f3;
        addr_i      = a;
        #4;
        chk({tag, "_stall"}, {31'h0, stall_o}, 32'd0);
        step();
        mem_read_i  = 1'b0;
        mem_write_i = 1'b0;
        #4;
        chk({tag, "_pulse"}, {31'h0, misalign_o}, 32'd1);
        chk({tag, "_noreq"}, {31'h0, dmem_if.req}, 32'd0);
        step();
        #4;
        chk({tag, "_clear"}, {31'h0, misalign_o}, 32'd0);
        step();
    endtask

    initial begin
        bus_t e;
        int   nreq;
        bit   tseen;
        logic [2:0] lf3 [5] = '{F3_B, F3_H, F3_W, F3_BU, F3_HU};
        mem_read_i     = 1'b0;
        mem_write_i    = 1'b0;
        flush_i        = 1'b0;
        funct3_i       = 3'b000;
        addr_i         = 32'h0;
        wdata_i        = 32'h0;
        dmem_if.gnt    = 1'b0;
        dmem_if.rvalid = 1'b0;
        dmem_if.rdata  = 32'h0;

        repeat (2) @(posedge clk);
        #5;
        chk("rst_stall", {31'h0, stall_o}, 32'd0);
        chk("rst_req", {31'h0, dmem_if.req}, 32'd0);
        chk("rst_valid", {31'h0, load_valid_o}, 32'd0);
        chk("rst_data", load_data_o, 32'd0);
        chk("rst_misalign", {31'h0, misalign_o}, 32'd0);
        chk("rst_timeout", {31'h0, timeout_o}, 32'd0);
        chk("rst_addr", dmem_if.addr, 32'd0);
        chk("rst_be", {28'h0, dmem_if.be}, 32'd0);
        rst_n = 1'b1;
        step();

        run_acc("sw", 1, F3_W, 32'h100, 32'hDEADBEEF, 32'h0, 0, 0);
        run_acc("lb", 0, F3_B, 32'h103, 32'h0, 32'h80FFFFFF, 0, 0);
        chk("lb_value", load_data_o, 32'hFFFFFF80);
        run_acc("lhu", 0, F3_HU, 32'h102, 32'h0, 32'hABCD1234, 0, 0);
        chk("lhu_value", load_data_o, 32'h0000ABCD);
        run_acc("sh", 1, F3_H, 32'h102, 32'h00001234, 32'h0, 0, 0);

        run_mis("lw_mis", 0, F3_W, 32'h101);
        run_mis("lh_mis", 0, F3_H, 32'h101);
        run_mis("sw_mis", 1, F3_W, 32'h102);
        run_mis("ld_ill", 0, 3'b011, 32'h100);
        run_mis("st_ill", 1, F3_BU, 32'h100);

        run_acc("slow_ld", 0, F3_W, 32'h180, 32'h0, 32'h13572468, 2, 1);

        for (int i = 0; i < 10; i++) begin
            bit          wr;
            logic [2:0]  f3;
            logic [1:0]  off;
            wr  = 1'($urandom_range(0, 1));
            f3  = wr ? 3'($urandom_range(0, 2)) : lf3[$urandom_range(0, 4)];
            off = (f3[1:0] == 2'd0) ? 2'($urandom_range(0, 3)) :
                  (f3[1:0] == 2'd1) ? {1'($urandom_range(0, 1)), 1'b0} : 2'd0;
            run_acc("rnd", wr, f3, {20'h0, 10'($urandom), off},
                    $urandom, $urandom, $urandom_range(0, 3),
                    $urandom_range(0, 2));
        end

        // Grant never comes: the request must be abandoned after the limit.
        nreq  = 0;
        tseen = 0;
        mem_read_i = 1'b1;
        funct3_i   = F3_W;
        addr_i     = 32'h1C0;
        for (int i = 0; i < 40 && !tseen; i++) begin
            #4;
            if (dmem_if.req) nreq++;
            if (timeout_o) begin
                tseen = 1;
                chk("tmo_stall", {31'h0, stall_o}, 32'd0);
                chk("tmo_valid", {31'h0, load_valid_o}, 32'd0);
            end
            step();
        end
        mem_read_i = 1'b0;
        chk("tmo_seen", {31'h0, tseen}, 32'd1);
        chk("tmo_req_cycles", nreq, 32'd15);
        #4;
        chk("tmo_clear", {31'h0, timeout_o}, 32'd0);
        step();

        // Flush while waiting for read data: the rvalid is swallowed.
        e = '{we: 1'b0, addr: 32'h200, be: 4'hF, wd: 32'h0};
        exp_bus.push_back(e);
        mem_read_i = 1'b1;
        funct3_i   = F3_W;
        addr_i     = 32'h200;
        #4;
        chk("fl_idle_stall", {31'h0, stall_o}, 32'd1);
        step();
        dmem_if.gnt = 1'b1;
        step();
        dmem_if.gnt = 1'b0;
        flush_i     = 1'b1;
        mem_read_i  = 1'b0;
        #4;
        chk("fl_resp_stall", {31'h0, stall_o}, 32'd0);
        step();
        flush_i        = 1'b0;
        dmem_if.rvalid = 1'b1;
        dmem_if.rdata  = 32'h12345678;
        #4;
        chk("fl_rv_stall", {31'h0, stall_o}, 32'd0);
        step();
        dmem_if.rvalid = 1'b0;
        #4;
        chk("fl_no_valid0", {31'h0, load_valid_o}, 32'd0);
        step();
        #4;
        chk("fl_no_valid1", {31'h0, load_valid_o}, 32'd0);
        step();
        run_acc("after_fl", 0, F3_H, 32'h206, 32'h0, 32'h8001_7FFF, 0, 0);

        // Flush before grant drops the request.
        mem_read_i = 1'b1;
        funct3_i   = F3_W;
        addr_i     = 32'h240;
        step();
        flush_i    = 1'b1;
        mem_read_i = 1'b0;
        #4;
        chk("flreq_stall", {31'h0, stall_o}, 32'd0);
        step();
        flush_i = 1'b0;
        #4;
        chk("flreq_noreq", {31'h0, dmem_if.req}, 32'd0);
        step();
        run_acc("after_flreq", 1, F3_B, 32'h241, 32'h000000A5, 32'h0, 1, 0);

        // Asynchronous reset in the middle of a request.
        mem_read_i = 1'b1;
        funct3_i   = F3_W;
        addr_i     = 32'h300;
        step();
        mem_read_i = 1'b0;
        #2;
        chk("arst_req_before", {31'h0, dmem_if.req}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_req_drop", {31'h0, dmem_if.req}, 32'd0);
        chk("arst_stall", {31'h0, stall_o}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        run_acc("after_rst", 0, F3_BU, 32'h301, 32'h0, 32'h0000_9900, 0, 1);

        chk("sb_empty", exp_bus.size() + exp_ld.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
